// File: rtl/keypad_emulator_if.sv
// Key-code stream handshake between a stimulus source and the keypad emulator.
// A transfer occurs on a clock edge where key_valid and key_ready are both high.
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Emulates a 4x3 matrix keypad: queued key codes are pressed and released one
// at a time by answering the scanner's row drive on the column return lines.
module keypad_emulator #(
  parameter int FIFO_DEPTH     = 8,
  parameter int PRESS_CYCLES   = 2000000,
  parameter int RELEASE_CYCLES = 2000000,
  parameter int CNT_WIDTH      = 22
) (
  input  logic                clk,
  input  logic                rstn,
  keypad_emulator_if.slave    key_if,
  input  logic [3:0]          i_keyboard_rows,
  output logic [2:0]          o_keyboard_cols,
  output logic                o_busy,
  output logic [3:0]          o_active_key,
  output logic                o_drop_err
);

  localparam int                   AW           = $clog2(FIFO_DEPTH);
  localparam logic [3:0]           NO_KEY       = 4'hF;
  localparam logic [CNT_WIDTH-1:0] PRESS_LOAD   = CNT_WIDTH'(PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RELEASE_LOAD = CNT_WIDTH'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE
  } state_t;

  // Key-code FIFO: one extra pointer bit distinguishes full from empty.
  logic [3:0]          r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic                r_drop_err;
  logic                w_empty;
  logic                w_full;
  logic                w_xfer;
  logic                w_code_ok;
  logic                w_push;
  logic                w_pop;
  logic [3:0]          w_head;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_WIDTH-1:0] r_timer;
  logic [CNT_WIDTH-1:0] w_timer_nxt;
  logic [3:0]          r_active_key;
  logic [3:0]          w_active_nxt;
  logic [1:0]          w_row_idx;
  logic [1:0]          w_col_idx;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_xfer    = key_if.key_valid && !w_full;
  assign w_code_ok = (key_if.key_code < 4'd12);
  assign w_push    = w_xfer && w_code_ok;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  assign key_if.key_ready = !w_full;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      r_drop_err <= w_xfer && !w_code_ok;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone say
  // which entries are valid, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= key_if.key_code;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_active_key <= NO_KEY;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_active_key <= w_active_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_active_nxt = r_active_key;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_active_nxt = w_head;
          w_timer_nxt  = PRESS_LOAD;
          w_state_nxt  = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (r_timer == '0) begin
          w_timer_nxt = RELEASE_LOAD;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_timer_nxt = r_timer - CNT_WIDTH'(1);
        end
      end
      ST_RELEASE: begin
        if (r_timer == '0) begin
          w_active_nxt = NO_KEY;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - CNT_WIDTH'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Column return is combinational so it answers the current scan step.
  assign w_row_idx = 2'(r_active_key / 4'd3);
  assign w_col_idx = 2'(r_active_key % 4'd3);

  always_comb begin
    o_keyboard_cols = 3'b111;
    if (rstn && (r_state == ST_PRESS)) begin
      o_keyboard_cols[w_col_idx] = i_keyboard_rows[w_row_idx];
    end
  end

  assign o_busy       = (r_state != ST_IDLE) || !w_empty;
  assign o_active_key = r_active_key;
  assign o_drop_err   = r_drop_err;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with short press/release timing so whole
// key sequences fit in a few hundred cycles.
module tb_keypad_emulator;

  localparam int PRESS = 4;
  localparam int REL   = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] rows;
  logic [2:0] cols;
  logic       busy;
  logic [3:0] active;
  logic       drop;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_emulator_if key_if ();

  keypad_emulator #(
    .FIFO_DEPTH    (DEPTH),
    .PRESS_CYCLES  (PRESS),
    .RELEASE_CYCLES(REL),
    .CNT_WIDTH     (4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .key_if         (key_if),
    .i_keyboard_rows(rows),
    .o_keyboard_cols(cols),
    .o_busy         (busy),
    .o_active_key   (active),
    .o_drop_err     (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] code);
    key_if.key_valid = 1'b1;
    key_if.key_code  = code;
    step();
    key_if.key_valid = 1'b0;
  endtask

  task automatic wait_active(output int cycles);
    cycles = 0;
    while (active == 4'hF && cycles < 50) begin
      step();
      cycles++;
    end
  endtask

  // Follows one full press/release of the expected key, with its row driven low.
  task automatic run_key(input logic [3:0] code, input int exp_gap);
    int         gap;
    int         press;
    int         rel;
    logic [1:0] r;
    logic [1:0] c;
    logic [2:0] exp_cols;
    r = 2'(code / 4'd3);
    c = 2'(code % 4'd3);
    exp_cols = ~(3'b001 << c);
    wait_active(gap);
    check("gap_to_press", 32'(gap), 32'(exp_gap));
    check("active_key", 32'(active), 32'(code));
    for (int i = 0; i < 4; i++) begin
      if (i != int'(r)) begin
        rows = ~(4'b0001 << i);
        #1;
        check("other_row_cols", 32'(cols), 32'h7);
      end
    end
    rows = ~(4'b0001 << r);
    #1;
    check("press_cols", 32'(cols), 32'(exp_cols));
    press = 0;
    while (cols == exp_cols && press < 50) begin
      press++;
      step();
    end
    check("press_len", 32'(press), 32'(PRESS));
    rel = 0;
    while (active == code && cols == 3'b111 && rel < 50) begin
      rel++;
      step();
    end
    check("release_len", 32'(rel), 32'(REL));
    rows = 4'hF;
  endtask

  initial begin
    logic [3:0] seq[$];
    logic [3:0] prev;
    int         w;

    rstn = 1'b0;
    rows = 4'hF;
    key_if.key_valid = 1'b0;
    key_if.key_code  = 4'h0;
    step();
    step();
    check("rst_cols", 32'(cols), 32'h7);
    check("rst_active", 32'(active), 32'hF);
    check("rst_ready", 32'(key_if.key_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_drop", 32'(drop), 32'h0);
    rstn = 1'b1;
    step();

    // Single key: code 5 = row 1, col 2.
    fork
      push(4'd5);
      run_key(4'd5, 2);
    join
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_active_none", 32'(active), 32'hF);

    // Back-to-back keys in FIFO order with one IDLE cycle between them.
    fork
      begin
        push(4'd0);
        push(4'd11);
        push(4'd7);
      end
      begin
        run_key(4'd0, 2);
        run_key(4'd11, 1);
        run_key(4'd7, 1);
      end
    join
    check("t2_busy_low", 32'(busy), 32'h0);

    // Fill: nine pushes (first one popped), then a refused push during a pop.
    for (int i = 0; i < 9; i++) begin
      key_if.key_valid = 1'b1;
      key_if.key_code  = 4'(i + 1);
      check("t3_ready_fill", 32'(key_if.key_ready), 32'h1);
      step();
    end
    key_if.key_code = 4'd10;
    check("t3_ready_full", 32'(key_if.key_ready), 32'h0);
    step();
    key_if.key_valid = 1'b0;
    check("t3_ready_back", 32'(key_if.key_ready), 32'h1);
    prev = 4'hF;
    for (int n = 0; n < 200 && busy; n++) begin
      if (active != 4'hF && active != prev) seq.push_back(active);
      prev = active;
      step();
    end
    check("t3_drained", 32'(busy), 32'h0);
    check("t3_key_count", 32'(seq.size()), 32'd8);
    for (int i = 0; i < seq.size() && i < 8; i++) begin
      check("t3_key_order", 32'(seq[i]), 32'(i + 2));
    end

    // Invalid code is handshaken and dropped.
    rows = 4'b0000;
    key_if.key_valid = 1'b1;
    key_if.key_code  = 4'd13;
    check("t4_ready", 32'(key_if.key_ready), 32'h1);
    step();
    key_if.key_valid = 1'b0;
    check("t4_drop_pulse", 32'(drop), 32'h1);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_cols", 32'(cols), 32'h7);
    step();
    check("t4_drop_end", 32'(drop), 32'h0);
    check("t4_busy_after", 32'(busy), 32'h0);
    rows = 4'hF;
    fork
      push(4'd3);
      run_key(4'd3, 2);
    join

    // All rows low selects only the active key; reset mid-press flushes all.
    fork
      begin
        push(4'd4);
        push(4'd6);
        push(4'd8);
      end
      wait_active(w);
    join
    check("t5_active", 32'(active), 32'h4);
    rows = 4'b0000;
    #1;
    check("t5_all_rows_cols", 32'(cols), 32'h5);
    rstn = 1'b0;
    #1;
    check("t5_cols_in_reset", 32'(cols), 32'h7);
    step();
    check("t5_cols_after", 32'(cols), 32'h7);
    check("t5_active_after", 32'(active), 32'hF);
    check("t5_ready_after", 32'(key_if.key_ready), 32'h1);
    check("t5_busy_after", 32'(busy), 32'h0);
    rstn = 1'b1;
    repeat (6) step();
    check("t5_queue_lost", 32'(active), 32'hF);
    check("t5_idle_busy", 32'(busy), 32'h0);
    check("t5_idle_cols", 32'(cols), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
